alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/response front-end for the registered ALU: one operation in flight at a time.
// Optional zero-flag consistency check is compiled in when ALU_ZCHECK_EN is defined.
module alu_issue_ctrl #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned OP_WIDTH    = 2,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_in1,
  input  logic [DATA_WIDTH-1:0] req_in2,
  input  logic [OP_WIDTH-1:0]   req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_out,
  output logic                  rsp_z,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_z,
  output logic                  busy,
  output logic [15:0]           op_count,
  output logic                  z_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [3:0] LatCnt = ALU_LATENCY[3:0];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] in1_q, in1_d;
  logic [DATA_WIDTH-1:0] in2_q, in2_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  z_q, z_d;
  logic [15:0]           count_q, count_d;
  logic                  cap_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    count_d = count_q;
    cap_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          in1_d   = req_in1;
          in2_d   = req_in2;
          op_d    = req_op;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = 4'd0;
        if (ALU_LATENCY == 0) begin
          cap_en  = 1'b1;
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 4'd1;
        // Capture on the edge where the incremented count hits the ALU latency.
        if (cnt_d == LatCnt) begin
          cap_en  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          count_d = count_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d = out_q;
    z_d   = z_q;
    if (cap_en) begin
      out_d = alu_out;
      z_d   = alu_z;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
      z_q     <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      out_q   <= out_d;
      z_q     <= z_d;
      count_q <= count_d;
    end
  end

`ifdef ALU_ZCHECK_EN
  logic z_err_q, z_err_d;

  // Flag an ALU whose zero flag disagrees with its own result; sticky until reset.
  always_comb begin
    z_err_d = z_err_q;
    if (cap_en && (alu_z != (alu_out == '0))) begin
      z_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      z_err_q <= 1'b0;
    end else begin
      z_err_q <= z_err_d;
    end
  end

  assign z_err = z_err_q;
`else
  assign z_err = 1'b0;
`endif

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign rsp_out   = out_q;
  assign rsp_z     = z_q;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign alu_op    = op_q;
  assign op_count  = count_q;

`ifndef SYNTHESIS
  rsp_hold_a: assert property (@(posedge clock) disable iff (!reset_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_out) && $stable(rsp_z)));
  one_hot_a: assert property (@(posedge clock) disable iff (!reset_n)
    !(req_ready && rsp_valid));
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl at ALU latencies 1, 0 and 3, each with a behavioural ALU stub.
module tb_alu_issue_ctrl;

  logic        clock;
  logic        reset_n;
  logic        req_valid[3], req_ready[3], rsp_valid[3], rsp_ready[3], rsp_z[3];
  logic        alu_z[3], busy[3], z_err[3], force_bad_z[3];
  logic [15:0] req_in1[3], req_in2[3], rsp_out[3], alu_in1[3], alu_in2[3], alu_out[3];
  logic [15:0] op_count[3];
  logic [1:0]  req_op[3], alu_op[3];

  logic [16:0] sb_q[$];
  int          checks;
  int          errors;
  int          cnt_model[3];

`ifdef ALU_ZCHECK_EN
  localparam logic ZERR_EXP = 1'b1;
`else
  localparam logic ZERR_EXP = 1'b0;
`endif

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [15:0] f_out;
    logic        f_z;

    always_comb begin
      f_out = alu_f(alu_in1[g], alu_in2[g], alu_op[g]);
      f_z   = force_bad_z[g] ? 1'b1 : (f_out == 16'd0);
    end

    if (L == 0) begin : g_comb
      assign alu_out[g] = f_out;
      assign alu_z[g]   = f_z;
    end else begin : g_pipe
      logic [15:0] po[L];
      logic        pz[L];
      always_ff @(posedge clock) begin
        po[0] <= f_out;
        pz[0] <= f_z;
        for (int k = 1; k < int'(L); k++) begin
          po[k] <= po[k-1];
          pz[k] <= pz[k-1];
        end
      end
      assign alu_out[g] = po[L-1];
      assign alu_z[g]   = pz[L-1];
    end

    alu_issue_ctrl #(
      .DATA_WIDTH (16),
      .OP_WIDTH   (2),
      .ALU_LATENCY(L)
    ) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_in1  (req_in1[g]),
      .req_in2  (req_in2[g]),
      .req_op   (req_op[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_out  (rsp_out[g]),
      .rsp_z    (rsp_z[g]),
      .alu_in1  (alu_in1[g]),
      .alu_in2  (alu_in2[g]),
      .alu_op   (alu_op[g]),
      .alu_out  (alu_out[g]),
      .alu_z    (alu_z[g]),
      .busy     (busy[g]),
      .op_count (op_count[g]),
      .z_err    (z_err[g])
    );
  end

  // Drive a request and wait for its acceptance; the expected result enters the scoreboard.
  task automatic issue_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op, output time t_acc);
    logic [15:0] r;
    int n;
    @(negedge clock);
    req_in1[i]   = a;
    req_in2[i]   = b;
    req_op[i]    = op;
    req_valid[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 30) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (req_ready[i] !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: req_ready=%b required 1", i, req_ready[i]);
      req_valid[i] = 1'b0;
      t_acc = 0;
      return;
    end
    r = alu_f(a, b, op);
    sb_q.push_back({(force_bad_z[i] ? 1'b1 : (r == 16'd0)), r});
    @(posedge clock);
    t_acc = $time;
    #1;
    req_valid[i] = 1'b0;
  endtask

  // Wait for the response, optionally stall and pre-present a follow-on request, then take it.
  task automatic collect_rsp(input int i, input int stall, input bit raise_next,
                             input logic [15:0] a2, input logic [15:0] b2,
                             input logic [1:0] op2, output time t_hs);
    int lat;
    logic [15:0] hold_out;
    logic hold_z;
    logic [16:0] exp;
    lat = 0;
    t_hs = 0;
    while (!rsp_valid[i] && lat < 40) begin
      @(posedge clock);
      lat++;
      #1;
    end
    checks++;
    if (lat != lat_of(i) + 1) begin
      errors++;
      $display("FAIL rsp_latency dut%0d: edges=%0d required %0d", i, lat, lat_of(i) + 1);
    end
    if (rsp_valid[i] !== 1'b1) begin
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    hold_out = rsp_out[i];
    hold_z   = rsp_z[i];
    if (raise_next) begin
      @(negedge clock);
      req_in1[i]   = a2;
      req_in2[i]   = b2;
      req_op[i]    = op2;
      req_valid[i] = 1'b1;
    end
    repeat (stall) begin
      @(posedge clock);
      #1;
      checks++;
      if (rsp_valid[i] !== 1'b1 || rsp_out[i] !== hold_out || rsp_z[i] !== hold_z ||
          req_ready[i] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold dut%0d: valid=%b out=%h z=%b ready=%b required 1 %h %b 0",
                 i, rsp_valid[i], rsp_out[i], rsp_z[i], req_ready[i], hold_out, hold_z);
      end
    end
    @(negedge clock);
    rsp_ready[i] = 1'b1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty dut%0d: got out=%h with nothing expected", i, rsp_out[i]);
    end else begin
      exp = sb_q.pop_front();
      if ({rsp_z[i], rsp_out[i]} !== exp) begin
        errors++;
        $display("FAIL result dut%0d: z=%b out=%h required z=%b out=%h",
                 i, rsp_z[i], rsp_out[i], exp[16], exp[15:0]);
      end
    end
    @(posedge clock);
    t_hs = $time;
    #1;
    rsp_ready[i] = 1'b0;
    cnt_model[i] = (cnt_model[i] + 1) & 16'hFFFF;
    checks++;
    if (op_count[i] !== 16'(cnt_model[i]) || rsp_valid[i] !== 1'b0) begin
      errors++;
      $display("FAIL op_count dut%0d: count=%0d valid=%b required %0d 0",
               i, op_count[i], rsp_valid[i], cnt_model[i]);
    end
  endtask

  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op);
    time ta, th;
    issue_req(i, a, b, op, ta);
    collect_rsp(i, 0, 1'b0, 16'd0, 16'd0, 2'd0, th);
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    checks++;
    if ({req_ready[i], rsp_valid[i], busy[i], z_err[i], rsp_z[i]} !== 5'b10000 ||
        rsp_out[i] !== 16'd0 || alu_in1[i] !== 16'd0 || alu_in2[i] !== 16'd0 ||
        alu_op[i] !== 2'd0 || op_count[i] !== 16'd0) begin
      errors++;
      $display("FAIL %s dut%0d: rdy/vld/busy/zerr/z=%b%b%b%b%b out=%h in=%h,%h,%h cnt=%0d required 10000 zeros",
               tag, i, req_ready[i], rsp_valid[i], busy[i], z_err[i], rsp_z[i], rsp_out[i],
               alu_in1[i], alu_in2[i], alu_op[i], op_count[i]);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 3; i++) cnt_model[i] = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    time ta;
    int seen;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) check_reset_vals(i, "reset_initial");
    reset_n = 1'b1;
    // Abort an operation in the middle of the latency-3 wait.
    issue_req(2, 16'd9, 16'd4, 2'd0, ta);
    @(posedge clock);
    #1;
    checks++;
    if (busy[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait dut2: busy=%b valid=%b required 1 0", busy[2], rsp_valid[2]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals(2, "reset_async");
    sb_q.delete();
    for (int i = 0; i < 3; i++) cnt_model[i] = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (rsp_valid[2] === 1'b1 || busy[2] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abort dut2: active cycles after release=%0d required 0", seen);
    end
  endtask

  task automatic test_single();
    run_op(0, 16'd3, 16'd2, 2'd1);
  endtask

  task automatic test_zero_result();
    run_op(0, 16'd3, 16'd3, 2'd1);
    run_op(0, 16'd4, 16'd2, 2'd1);
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (alu_in1[0] !== 16'd4 || alu_in2[0] !== 16'd2 || alu_op[0] !== 2'd1 || busy[0] !== 1'b0)
    begin
      errors++;
      $display("FAIL alu_hold dut0: in=%0d,%0d,%0d busy=%b required 4,2,1 0",
               alu_in1[0], alu_in2[0], alu_op[0], busy[0]);
    end
  endtask

  task automatic test_backpressure();
    time ta, th;
    issue_req(0, 16'd7, 16'd2, 2'd0, ta);
    collect_rsp(0, 5, 1'b1, 16'h1234, 16'h0FF0, 2'd2, th);
    checks++;
    if (req_ready[0] !== 1'b1 || busy[0] !== 1'b0 || alu_in1[0] !== 16'd7) begin
      errors++;
      $display("FAIL post_handshake dut0: ready=%b busy=%b in1=%h required 1 0 0007",
               req_ready[0], busy[0], alu_in1[0]);
    end
    issue_req(0, 16'h1234, 16'h0FF0, 2'd2, ta);
    checks++;
    if (ta != th + 10) begin
      errors++;
      $display("FAIL second_accept dut0: accepted at %0t required %0t", ta, th + 10);
    end
    collect_rsp(0, 0, 1'b0, 16'd0, 16'd0, 2'd0, th);
  endtask

  task automatic test_latency_sweep();
    run_op(1, 16'd101, 16'd7, 2'd0);
    run_op(1, 16'h00F0, 16'h000F, 2'd3);
    run_op(2, 16'd102, 16'd7, 2'd1);
    run_op(2, 16'h5555, 16'hAAAA, 2'd2);
  endtask

  task automatic test_back_to_back();
    time ta, th, prev;
    logic [15:0] a, b;
    logic [1:0] op;
    for (int d = 0; d < 3; d += 2) begin
      prev = 0;
      for (int n = 0; n < 4; n++) begin
        a  = 16'($urandom);
        b  = 16'($urandom);
        op = 2'($urandom_range(0, 3));
        issue_req(d, a, b, op, ta);
        if (n > 0) begin
          checks++;
          if (ta - prev != time'((lat_of(d) + 3) * 10)) begin
            errors++;
            $display("FAIL throughput dut%0d: interval=%0t required %0d", d, ta - prev,
                     (lat_of(d) + 3) * 10);
          end
        end
        prev = ta;
        collect_rsp(d, 0, 1'b0, 16'd0, 16'd0, 2'd0, th);
      end
    end
  endtask

  task automatic test_zcheck();
    time ta, th;
    force_bad_z[0] = 1'b1;
    issue_req(0, 16'd2, 16'd3, 2'd0, ta);
    collect_rsp(0, 0, 1'b0, 16'd0, 16'd0, 2'd0, th);
    force_bad_z[0] = 1'b0;
    checks++;
    if (z_err[0] !== ZERR_EXP) begin
      errors++;
      $display("FAIL z_err_set dut0: z_err=%b required %b", z_err[0], ZERR_EXP);
    end
    run_op(0, 16'd1, 16'd1, 2'd1);
    run_op(0, 16'd8, 16'd1, 2'd1);
    checks++;
    if (z_err[0] !== ZERR_EXP || z_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL z_err_sticky: dut0=%b dut1=%b required %b 0", z_err[0], z_err[1], ZERR_EXP);
    end
    apply_reset();
    #1;
    check_reset_vals(0, "z_err_reset");
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i]   = 1'b0;
      rsp_ready[i]   = 1'b0;
      req_in1[i]     = 16'd0;
      req_in2[i]     = 16'd0;
      req_op[i]      = 2'd0;
      force_bad_z[i] = 1'b0;
      cnt_model[i]   = 0;
    end
    test_reset();
    test_single();
    test_zero_result();
    test_backpressure();
    test_latency_sweep();
    test_back_to_back();
    test_zcheck();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
